// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scancode prefix constants.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 line.
// The filtered output only flips after FILTER_LEN consecutive synchronized
// samples disagree with it; everything resets to 1 so an idle bus stays idle.
`timescale 1ns/1ps
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;

  // Synchronize the raw line, then down-count a run of disagreeing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      filt_o  <= 1'b1;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
      if (sync_q2 == filt_o) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        filt_o <= sync_q2;
        cnt_q  <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: filters kclk/kdata, frames 11-bit packets and folds
// E0/F0 prefixes into flags that accompany the next scancode.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a falling edge with kdata=0 (start bit)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | sampling the odd-parity bit
//   ST_STOP   | sampling the stop bit, then publishing byte or error
`timescale 1ns/1ps
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       valid_o,
  output logic       break_o,
  output logic       extended_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic          kclk_f;
  logic          kdata_f;
  logic          kclk_q;
  logic          fall_edge;
  ps2_state_e    state_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_ok_q;
  logic [TW-1:0] tmo_q;
  logic          ext_flag_q;
  logic          brk_flag_q;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_kclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (kclk_i),
    .filt_o (kclk_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_kdata (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (kdata_i),
    .filt_o (kdata_f)
  );

  // Delay the filtered clock by one cycle to detect its 1->0 transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) kclk_q <= 1'b1;
    else       kclk_q <= kclk_f;
  end

  assign fall_edge = kclk_q & ~kclk_f;
  assign busy_o    = (state_q != ST_IDLE);

  // Frame FSM with inter-edge timeout; valid/err are registered one-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      parity_ok_q <= 1'b0;
      tmo_q       <= '0;
      ext_flag_q  <= 1'b0;
      brk_flag_q  <= 1'b0;
      keycode_o   <= 8'h00;
      valid_o     <= 1'b0;
      break_o     <= 1'b0;
      extended_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (fall_edge) begin
        tmo_q <= TMO_LOAD;
        case (state_q)
          ST_IDLE: begin
            if (!kdata_f) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg_q <= {kdata_f, shreg_q[7:1]};
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          ST_PARITY: begin
            parity_ok_q <= ^{shreg_q, kdata_f};
            state_q     <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (kdata_f && parity_ok_q) begin
              if (shreg_q == PS2_EXT) begin
                ext_flag_q <= 1'b1;
              end else if (shreg_q == PS2_BRK) begin
                brk_flag_q <= 1'b1;
              end else begin
                keycode_o  <= shreg_q;
                break_o    <= brk_flag_q;
                extended_o <= ext_flag_q;
                valid_o    <= 1'b1;
                ext_flag_q <= 1'b0;
                brk_flag_q <= 1'b0;
              end
            end else begin
              err_o      <= 1'b1;
              ext_flag_q <= 1'b0;
              brk_flag_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (tmo_q == '0) begin
          state_q    <= ST_IDLE;
          err_o      <= 1'b1;
          ext_flag_q <= 1'b0;
          brk_flag_q <= 1'b0;
        end else begin
          tmo_q <= tmo_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with a queue-based scoreboard and monitor.
`timescale 1ns/1ps
module tb_ps2_receiver;

  localparam int CLK_HALF = 50;      // 10 MHz clk_i
  localparam int SLOW_HALF = 50000;  // 100 us bit period
  localparam int FAST_HALF = 5000;   // 10 us bit period
  localparam int TMO = 2000;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic [7:0] keycode;
  logic       valid, brk_o, ext_o, err, busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .kclk_i     (kclk),
    .kdata_i    (kdata),
    .keycode_o  (keycode),
    .valid_o    (valid),
    .break_o    (brk_o),
    .extended_o (ext_o),
    .err_o      (err),
    .busy_o     (busy)
  );

  always #CLK_HALF clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_code(input logic [7:0] code, input bit b, input bit e);
    exp_t x;
    x.is_err = 1'b0; x.code = code; x.brk = b; x.ext = e;
    exp_q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1; x.code = 8'h00; x.brk = 1'b0; x.ext = 1'b0;
    exp_q.push_back(x);
  endtask

  // Drive nbits of a frame: start, 8 data LSB-first, odd parity, stop.
  task automatic send_frame(input logic [7:0] data, input bit bad_par,
                            input int half, input int nbits, input bit glitch);
    logic [10:0] bits;
    logic        par;
    par  = ~(^data) ^ bad_par;
    bits = {1'b1, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        #(half / 2);
        kclk = 1'b0;
        #300;
        kclk = 1'b1;
        #(half / 2 - 300);
      end else begin
        #half;
      end
      kclk = 1'b0;
      if (glitch && i >= 2 && i <= 7) begin
        #(half / 2);
        kclk = 1'b1;
        #200;
        kclk = 1'b0;
        #(half / 2 - 200);
      end else begin
        #half;
      end
      kclk = 1'b1;
    end
    kdata = 1'b1;
    #(half * 2);
  endtask

  // Monitor: every output event is matched against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && err) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_err_overlap: valid=%0b err=%0b expected not both", valid, err);
      end else if (valid || err) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: valid=%0b err=%0b code=%0h expected none",
                   valid, err, keycode);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_err) begin
            if (!err) begin
              n_fail++;
              $display("FAIL event_kind: got valid code=%0h expected err", keycode);
            end
          end else if (!valid || keycode !== e.code || brk_o !== e.brk || ext_o !== e.ext) begin
            n_fail++;
            $display("FAIL scancode: got valid=%0b code=%0h brk=%0b ext=%0b expected code=%0h brk=%0b ext=%0b",
                     valid, keycode, brk_o, ext_o, e.code, e.brk, e.ext);
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_keycode"}, {24'h0, keycode}, 32'h00);
    check({tag, "_valid"},   {31'h0, valid},   32'h0);
    check({tag, "_break"},   {31'h0, brk_o},   32'h0);
    check({tag, "_ext"},     {31'h0, ext_o},   32'h0);
    check({tag, "_err"},     {31'h0, err},     32'h0);
    check({tag, "_busy"},    {31'h0, busy},    32'h0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Plain make code at 100 us bit period.
    push_code(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, SLOW_HALF, 11, 1'b0);

    // Break prefix, then a plain code with flags cleared.
    send_frame(8'hF0, 1'b0, FAST_HALF, 11, 1'b0);
    push_code(8'h16, 1'b1, 1'b0);
    send_frame(8'h16, 1'b0, FAST_HALF, 11, 1'b0);
    push_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, FAST_HALF, 11, 1'b0);

    // Extended release.
    send_frame(8'hE0, 1'b0, FAST_HALF, 11, 1'b0);
    send_frame(8'hF0, 1'b0, FAST_HALF, 11, 1'b0);
    push_code(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, FAST_HALF, 11, 1'b0);

    // Parity error followed by recovery.
    push_err();
    send_frame(8'h16, 1'b1, FAST_HALF, 11, 1'b0);
    push_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, FAST_HALF, 11, 1'b0);

    // Truncated frame: timeout, then a clean frame.
    push_err();
    send_frame(8'h5A, 1'b0, FAST_HALF, 5, 1'b0);
    #(3 * TMO * 2 * CLK_HALF);
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    push_code(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, FAST_HALF, 11, 1'b0);

    // Short glitches on kclk during data bits.
    push_code(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, FAST_HALF, 11, 1'b1);

    // Break prefix, partial frame, then reset: flags and frame discarded.
    send_frame(8'hF0, 1'b0, FAST_HALF, 11, 1'b0);
    send_frame(8'h16, 1'b0, FAST_HALF, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    #(3 * TMO * 2 * CLK_HALF);
    push_code(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, FAST_HALF, 11, 1'b0);

    #(40 * FAST_HALF);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
